// File: rtl/axi_ic_pkg.sv
// ----------------------------------------------------------------------------
// axi_ic_pkg : shared interconnect types (default widths, FIFO entry, slice FSM)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_ic_pkg;

  localparam int IDW_DEF = 4;
  localparam int SW_DEF  = 2;

  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic [SW_DEF-1:0]  slv;
  } ord_ent_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slice_st_e;

endpackage

`default_nettype wire

// File: rtl/axi_ord_guard_if.sv
// ----------------------------------------------------------------------------
// axi_ord_guard_if : request, forward, and FIFO-side signals of the ordering guard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi_ord_guard_if
  import axi_ic_pkg::*;
#(
  parameter int IDW = IDW_DEF,
  parameter int SW  = SW_DEF,
  parameter int DP  = 4
) ();

  logic                          i_req_valid;
  logic                          o_req_ready;
  logic [IDW-1:0]                i_req_id;
  logic [SW-1:0]                 i_req_slv;
  logic                          o_req_valid;
  logic                          i_req_ready;
  logic [IDW-1:0]                o_req_id;
  logic [SW-1:0]                 o_req_slv;
  logic                          i_rsp_done;
  logic                          o_push;
  logic [IDW+SW-1:0]             o_push_data;
  logic                          o_pop;
  logic [DP-1:0][IDW+SW-1:0]     i_fifo_data;
  logic [DP-1:0]                 i_fifo_valid;
  logic                          i_fifo_full;
  logic [DP-1:0]                 o_match_hit;

  // Guard side.
  modport slave (
    input  i_req_valid, i_req_id, i_req_slv, i_req_ready, i_rsp_done,
           i_fifo_data, i_fifo_valid, i_fifo_full,
    output o_req_ready, o_req_valid, o_req_id, o_req_slv,
           o_push, o_push_data, o_pop, o_match_hit
  );

  // Environment side (upstream master, downstream slave, FIFO).
  modport master (
    output i_req_valid, i_req_id, i_req_slv, i_req_ready, i_rsp_done,
           i_fifo_data, i_fifo_valid, i_fifo_full,
    input  o_req_ready, o_req_valid, o_req_id, o_req_slv,
           o_push, o_push_data, o_pop, o_match_hit
  );

endinterface

`default_nettype wire

// File: rtl/axi_id_match.sv
// ----------------------------------------------------------------------------
// axi_id_match : flags FIFO entries holding the request ID bound for another slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_id_match #(
  parameter int IDW = 4,
  parameter int SW  = 2,
  parameter int DP  = 4
) (
  input  logic [IDW-1:0]             i_req_id,
  input  logic [SW-1:0]              i_req_slv,
  input  logic [DP-1:0][IDW+SW-1:0]  i_fifo_data,
  input  logic [DP-1:0]              i_fifo_valid,
  output logic                       o_conflict,
  output logic [DP-1:0]              o_hit
);

  for (genvar k = 0; k < DP; k++) begin : g_ent
    assign o_hit[k] = i_fifo_valid[k]
                    & (i_fifo_data[k][IDW+SW-1:SW] == i_req_id)
                    & (i_fifo_data[k][SW-1:0] != i_req_slv);
  end

  assign o_conflict = |o_hit;

endmodule

`default_nettype wire

// File: rtl/axi_ord_guard.sv
// ----------------------------------------------------------------------------
// axi_ord_guard : same-ID ordering guard with one-entry registered output slice.
// Optional stall counter output: define AXI_ORD_GUARD_STALL_CNT_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_ord_guard
  import axi_ic_pkg::*;
#(
  parameter int IDW = IDW_DEF,
  parameter int SW  = SW_DEF,
  parameter int DP  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  axi_ord_guard_if.slave     bus
`ifdef AXI_ORD_GUARD_STALL_CNT_EN
  ,
  output logic [15:0]        o_stall_cnt
`endif
);

  logic           conflict;
  logic           ready;
  logic           accept;
  slice_st_e      state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [SW-1:0]  slv_q, slv_d;

  axi_id_match #(
    .IDW (IDW),
    .SW  (SW),
    .DP  (DP)
  ) u_id_match (
    .i_req_id     (bus.i_req_id),
    .i_req_slv    (bus.i_req_slv),
    .i_fifo_data  (bus.i_fifo_data),
    .i_fifo_valid (bus.i_fifo_valid),
    .o_conflict   (conflict),
    .o_hit        (bus.o_match_hit)
  );

  always_comb begin
    // A pop in the same cycle never frees a full FIFO for this request.
    ready   = ~i_reset & ~bus.i_fifo_full & ~conflict
            & ((state_q == EMPTY) | bus.i_req_ready);
    accept  = bus.i_req_valid & ready;
    state_d = state_q;
    id_d    = id_q;
    slv_d   = slv_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (bus.i_req_ready & ~accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      id_d  = bus.i_req_id;
      slv_d = bus.i_req_slv;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= EMPTY;
      id_q    <= '0;
      slv_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      slv_q   <= slv_d;
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_push      = accept;
  assign bus.o_push_data = {bus.i_req_id, bus.i_req_slv};
  assign bus.o_pop       = bus.i_rsp_done & ~i_reset;
  assign bus.o_req_valid = (state_q == FULL);
  assign bus.o_req_id    = id_q;
  assign bus.o_req_slv   = slv_q;

`ifdef AXI_ORD_GUARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.i_req_valid & ~ready & (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) stall_cnt_q <= '0;
    else         stall_cnt_q <= stall_cnt_d;
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/axi_ord_guard.md
# axi_ord_guard

Request-side ordering guard that sits directly upstream of the transparent outstanding-transaction FIFO (`axi_tpfifo`) in the AXI interconnect. It accepts address requests, carrying an ID and a destination slave index, from a master port. It stalls a request whose ID is outstanding to a *different* slave, which preserves AXI same-ID response ordering. Each accepted request is pushed into the FIFO, where it is visible as `{id, slv}`, and forwarded through a one-entry registered output slice. Completed transactions are popped on the response-done strobe.

## Interface
- `IDW`, 4, AXI ID width
- `SW`, 2, slave index width
- `DP`, 4, outstanding depth; must equal the FIFO depth; DP >= 2
- `i_clk`  in  1  clock
- `i_reset`  in  1  synchronous, active-high reset
- `i_req_valid`  in  1  upstream request valid
- `o_req_ready`  out  1  upstream request ready
- `i_req_id`  in  IDW  request ID
- `i_req_slv`  in  SW  decoded destination slave
- `o_req_valid`  out  1  downstream request valid (registered)
- `i_req_ready`  in  1  downstream ready
- `o_req_id`  out  IDW  registered ID
- `o_req_slv`  out  SW  registered slave index
- `i_rsp_done`  in  1  last response beat handshaken; retires one transaction
- `o_push`  out  1  FIFO push
- `o_push_data`  out  IDW+SW  `{id, slv}` (ID in the MSBs)
- `o_pop`  out  1  FIFO pop
- `i_fifo_data`  in  [DP] x (IDW+SW)  FIFO entry view
- `i_fifo_valid`  in  [DP] x 1  per-entry valid
- `i_fifo_full`  in  1  FIFO full

## Operation
- **Conflict check:**
  - `conflict` is set if any `k` has `i_fifo_valid[k]`, an ID field equal to `i_req_id`, and a slave field not equal to `i_req_slv`.
  - Same ID to the same slave never conflicts.
- **Accept condition:**
  - `accept = i_req_valid & o_req_ready`.
  - `o_req_ready = ~i_fifo_full & ~conflict & (state==EMPTY | i_req_ready)`.
- **Push:**
  - `o_push = accept` (combinational, same cycle).
  - `o_push_data = {i_req_id, i_req_slv}`.
- **Pop:** `o_pop = i_rsp_done`, unconditionally. The FIFO ignores a pop when it is empty.
- **Output-slice FSM:**
  - EMPTY to FULL on `accept`.
  - FULL to FULL on `accept & i_req_ready`; the slot is reloaded.
  - FULL to EMPTY on `i_req_ready & ~accept`.
  - FULL holds while `~i_req_ready`; the payload stays stable.
- **Outputs:** `o_req_valid = (state==FULL)`. `o_req_id` and `o_req_slv` load only on `accept`.
- **Upstream rule:** the upstream master must hold its payload stable while `i_req_valid & ~o_req_ready`.

## Timing
- **Reset:**
  - state = EMPTY.
  - `o_req_valid`=0, `o_req_id`=0, `o_req_slv`=0.
  - `o_push`, `o_pop` and `o_req_ready` are gated to 0 while `i_reset`=1.
- **Reset mid-operation:** any held request is dropped without being forwarded. The FIFO is reset on the same reset.
- **Latency:** accept in cycle N gives `o_req_valid`=1 in cycle N+1. The FIFO entry becomes visible in cycle N+1.
- **Throughput:** back-to-back accepts are allowed while downstream is ready, at one request per cycle.
- **Same-ID pipelining:** a request accepted in cycle N is seen by the conflict check from cycle N+1. A same-ID/different-slave request arriving in N+1 therefore stalls.
- **Push and pop in the same cycle:** both are issued.
- **Pop frees a conflict:** the conflicting entry is still in the view during the pop cycle, so the stall releases in the following cycle at the earliest.
- **Full:** `o_req_ready`=0 while `i_fifo_full`, even if downstream is ready. A pop in the same cycle does not bypass this.

## Configuration
- **`AXI_ORD_GUARD_STALL_CNT_EN` defined:**
  - Adds output `o_stall_cnt` [15:0].
  - The counter increments each cycle in which `i_req_valid & ~o_req_ready`, saturating at 16'hFFFF.
  - It is cleared by reset only.
- **Not defined:** the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- **Shared package `axi_ic_pkg`:**
  - Default widths `IDW`/`SW`.
  - Typedef `ord_ent_t` = `{id, slv}` packed struct.
  - FSM enum `slice_st_e` {EMPTY, FULL}.
- **One sub-module `axi_id_match`:**
  - Parameterized by DP.
  - Purely combinational compare of the request against all entries.
  - Outputs `conflict` and a per-entry hit vector, the latter for debug.

## Test plan
- Reset with `i_req_valid`=1 → `o_req_ready`=0, `o_push`=0; after release `o_req_valid`=0.
- Request id=3/slv=1 on an empty FIFO with `i_req_ready`=1:
  - same cycle: `o_push`=1, `o_push_data`=6'b0011_01;
  - next cycle: `o_req_valid`=1 with id 3, slv 1.
- Entry {3,1} valid, then request id=3/slv=2:
  - `o_req_ready`=0 until `i_rsp_done` pulses;
  - ready rises the cycle after the pop, once the view clears.
- Entry {3,1} valid, then request id=3/slv=1 → accepted without stall.
- Four accepts with `i_req_ready`=0 after the first:
  - second accept blocked, since the slot is FULL and downstream is not ready;
  - payload of the first stays stable;
  - releasing ready drains it, and `i_fifo_full`=1 blocks accepts thereafter.
- With `AXI_ORD_GUARD_STALL_CNT_EN`: hold a conflicting request for 10 cycles → `o_stall_cnt`=10.
